// File: rtl/axi_rd_arbiter.sv
// Two-requester (icache i / dcache d) AXI3 read arbiter: one burst in flight, d priority,
// starvation limiter forces i. Define AXI_RD_ARB_RESP_ERR_EN for sticky rd_err / rd_err_id.
module axi_rd_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter logic [3:0]  ID_I         = 4'd0,
   parameter logic [3:0]  ID_D         = 4'd1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] i_araddr,
   input  logic [7:0]  i_arlen,
   input  logic        i_arvalid,
   output logic        i_arready,
   output logic [31:0] i_rdata,
   output logic        i_rlast,
   output logic        i_rvalid,
   input  logic        i_rready,
   input  logic [31:0] d_araddr,
   input  logic [7:0]  d_arlen,
   input  logic [2:0]  d_arsize,
   input  logic        d_arvalid,
   output logic        d_arready,
   output logic [31:0] d_rdata,
   output logic        d_rlast,
   output logic        d_rvalid,
   input  logic        d_rready,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
`ifdef AXI_RD_ARB_RESP_ERR_EN
   ,
   output logic        rd_err,
   output logic [3:0]  rd_err_id
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
   typedef enum logic [1:0] {G_NONE, G_I, G_D} gnt_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e      state_q, state_d;
   gnt_e        gnt_q, gnt_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        arvalid_q, arvalid_d;
   logic [31:0] araddr_q, araddr_d;
   logic [7:0]  arlen_q, arlen_d;
   logic [2:0]  arsize_q, arsize_d;
   logic [3:0]  arid_q, arid_d;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= S_IDLE;
         gnt_q     <= G_NONE;
         cnt_q     <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= 3'b010;
         arid_q    <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arid_q    <= arid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      arid_d    = arid_q;
      unique case (state_q)
         S_IDLE: begin
            // d wins unless i has already lost LIMIT times in a row
            if (d_arvalid && (cnt_q < LIMIT || !i_arvalid)) begin
               gnt_d     = G_D;
               araddr_d  = d_araddr;
               arlen_d   = d_arlen;
               arsize_d  = d_arsize;
               arid_d    = ID_D;
               arvalid_d = 1'b1;
               state_d   = S_ADDR;
               if (!i_arvalid)          cnt_d = '0;
               else if (cnt_q >= LIMIT) cnt_d = LIMIT;
               else                     cnt_d = cnt_q + 4'd1;
            end else if (i_arvalid) begin
               gnt_d     = G_I;
               araddr_d  = i_araddr;
               arlen_d   = i_arlen;
               arsize_d  = 3'b010;
               arid_d    = ID_I;
               arvalid_d = 1'b1;
               state_d   = S_ADDR;
               cnt_d     = '0;
            end
         end
         S_ADDR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (rvalid && rready && rlast) begin
               gnt_d   = G_NONE;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Ownership comes from the single outstanding burst, so rid is never consulted
   always_comb begin
      rready   = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
      if (state_q == S_DATA && gnt_q == G_I) begin
         rready   = i_rready;
         i_rvalid = rvalid;
      end else if (state_q == S_DATA && gnt_q == G_D) begin
         rready   = d_rready;
         d_rvalid = rvalid;
      end
   end

   assign i_arready = (gnt_q == G_I) && arvalid_q && arready;
   assign d_arready = (gnt_q == G_D) && arvalid_q && arready;
   assign i_rdata   = rdata;
   assign d_rdata   = rdata;
   assign i_rlast   = rlast;
   assign d_rlast   = rlast;
   assign arid      = arid_q;
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arsize    = arsize_q;
   assign arvalid   = arvalid_q;
   assign arburst   = 2'b01;
   assign arlock    = 2'b00;
   assign arcache   = 4'h0;
   assign arprot    = 3'h0;

`ifdef AXI_RD_ARB_RESP_ERR_EN
   logic       err_q;
   logic [3:0] err_id_q;

   // First error wins; later ones never overwrite the captured id
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_q    <= 1'b0;
         err_id_q <= '0;
      end else if (!err_q && rvalid && rready && rresp != 2'b00) begin
         err_q    <= 1'b1;
         err_id_q <= arid_q;
      end
   end

   assign rd_err    = err_q;
   assign rd_err_id = err_id_q;

   logic unused_rid;
   assign unused_rid = ^rid;
`else
   logic unused_rsp;
   assign unused_rsp = ^{rid, rresp};
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus random traffic against a burst-level
// ownership model (grant rule, starvation count, beat accounting, sticky error).
module tb_axi_rd_arbiter;
   localparam int LIM = 4;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
   } req_t;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, araddr, rdata;
   logic [7:0]  i_arlen, d_arlen, arlen;
   logic [2:0]  d_arsize, arsize, arprot;
   logic        i_arvalid, d_arvalid, i_arready, d_arready;
   logic        i_rlast, d_rlast, i_rvalid, d_rvalid, i_rready, d_rready;
   logic [3:0]  arid, arcache, rid;
   logic [1:0]  arburst, arlock, rresp;
   logic        arvalid, arready, rlast, rvalid, rready;
`ifdef AXI_RD_ARB_RESP_ERR_EN
   logic        rd_err;
   logic [3:0]  rd_err_id;
`endif

   always #5 aclk = ~aclk;

   axi_rd_arbiter #(.STARVE_LIMIT(LIM), .ID_I(4'd0), .ID_D(4'd1)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
      .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
      .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
      .d_rready(d_rready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef AXI_RD_ARB_RESP_ERR_EN
      , .rd_err(rd_err), .rd_err_id(rd_err_id)
`endif
   );

   int total = 0;
   int bad = 0;

   // stimulus knobs
   req_t i_q[$], d_q[$];
   int   p_req = 0, p_rr = 100, p_rv = 100, p_stray = 0, p_err = 0;
   int   ardly_fix = 0, d_hold = 0, err_beat = -1;
   bit   use_tbl = 1'b0;
   logic [31:0] tbl [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

   // memory-side slave
   bit          s_busy;
   int          s_left, s_beat, s_arcnt, s_ardly;
   logic [31:0] s_addr;
   logic [3:0]  s_id;

   // burst-level reference: owner 0=none 1=i 2=d
   int          m_owner, m_cnt, m_left, m_beat;
   bit          m_ar, m_err;
   req_t        m_req;
   logic [3:0]  m_id, m_err_id;

   logic [3:0]  gnt_log[$];
   logic [31:0] d_rx[$];
   int          i_rx_n, i_arr_n, bp_n;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
      if (use_tbl && b < 4) return tbl[b];
      return a ^ (32'h9E37_79B9 * 32'(b + 1));
   endfunction

   function automatic req_t rand_req(input bit is_i);
      req_t r;
      r.addr = $urandom & 32'hFFFF_FFFC;
      r.len  = 8'($urandom_range(7));
      r.size = is_i ? 3'b010 : 3'($urandom_range(2));
      return r;
   endfunction

   function automatic logic [63:0] log_word(input int n);
      logic [63:0] w = '1;
      for (int k = 0; k < n; k++) w = {w[59:0], (k < gnt_log.size()) ? gnt_log[k] : 4'hF};
      return w;
   endfunction

   task automatic clr_bench();
      i_q.delete(); d_q.delete();
      p_req = 0; d_hold = 0; err_beat = -1;
      i_arvalid = 0; i_araddr = 0; i_arlen = 0; i_rready = 0;
      d_arvalid = 0; d_araddr = 0; d_arlen = 0; d_arsize = 0; d_rready = 0;
      arready = 0; rvalid = 0; rdata = 0; rlast = 0; rresp = 0; rid = 0;
      s_busy = 0; s_left = 0; s_beat = 0; s_arcnt = 0; s_ardly = 0; s_addr = 0; s_id = 0;
      m_owner = 0; m_cnt = 0; m_left = 0; m_beat = 0; m_ar = 0; m_err = 0; m_err_id = 0;
      m_id = 0; m_req = '{32'h0, 8'h0, 3'h0};
   endtask

   // Inputs for the coming cycle, applied just after the rising edge
   task automatic drive();
      if (p_req > 0) begin
         if (i_q.size() == 0 && $urandom_range(99) < p_req) i_q.push_back(rand_req(1'b1));
         if (d_q.size() == 0 && $urandom_range(99) < p_req) d_q.push_back(rand_req(1'b0));
      end
      i_arvalid = (i_q.size() > 0);
      if (i_arvalid) begin i_araddr = i_q[0].addr; i_arlen = i_q[0].len; end
      d_arvalid = (d_q.size() > 0);
      if (d_arvalid) begin d_araddr = d_q[0].addr; d_arlen = d_q[0].len; d_arsize = d_q[0].size; end
      i_rready = ($urandom_range(99) < p_rr);
      if (d_hold > 0) begin d_rready = 0; d_hold--; end
      else d_rready = ($urandom_range(99) < p_rr);
      arready = arvalid && !s_busy && (s_arcnt >= ((ardly_fix >= 0) ? ardly_fix : s_ardly));
      if (s_busy) begin
         rvalid = ($urandom_range(99) < p_rv);
         rdata  = beat_data(s_addr, s_beat);
         rlast  = (s_left == 1);
         rid    = s_id;
         rresp  = (s_beat == err_beat || $urandom_range(99) < p_err) ? 2'b10 : 2'b00;
      end else begin
         rvalid = ($urandom_range(99) < p_stray);
         rdata  = $urandom;
         rlast  = 1'($urandom_range(1));
         rid    = 4'($urandom);
         rresp  = 2'($urandom);
      end
   endtask

   task automatic sample();
      logic exp_rr;
      @(negedge aclk);
      exp_rr = (m_owner == 1) ? i_rready : d_rready;
      chk("fixed", {arburst, arlock, arcache, arprot}, {2'b01, 2'b00, 4'h0, 3'h0});
      chk("bcast", {i_rdata, i_rlast, d_rdata, d_rlast}, {rdata, rlast, rdata, rlast});
`ifdef AXI_RD_ARB_RESP_ERR_EN
      chk("rd_err", {rd_err, rd_err_id}, {m_err, m_err_id});
`endif
      if (m_owner == 0) begin
         chk("idle_quiet", {arvalid, rready, i_rvalid, d_rvalid, i_arready, d_arready}, 6'b0);
      end else if (m_ar) begin
         chk("ar_fields", {arvalid, arid, araddr, arlen, arsize},
             {1'b1, m_id, m_req.addr, m_req.len, m_req.size});
         chk("ar_route", {i_arready, d_arready, rready, i_rvalid, d_rvalid},
             {arready && m_owner == 1, arready && m_owner == 2, 3'b000});
      end else begin
         chk("r_route", {arvalid, rready, i_rvalid, d_rvalid, i_arready, d_arready},
             {1'b0, exp_rr, rvalid && m_owner == 1, rvalid && m_owner == 2, 2'b00});
         if (rvalid && exp_rr)
            chk("r_beat", {(m_owner == 1) ? i_rdata : d_rdata, (m_owner == 1) ? i_rlast : d_rlast},
                {beat_data(m_req.addr, m_beat), m_left == 1});
         if (m_owner == 2 && rvalid && !rready) bp_n++;
      end

      // reference update for the coming edge
      if (m_owner == 0) begin
         if (d_arvalid && (m_cnt < LIM || !i_arvalid)) begin
            m_owner = 2; m_ar = 1; m_id = 4'd1;
            m_req   = '{d_araddr, d_arlen, d_arsize};
            m_cnt   = i_arvalid ? ((m_cnt + 1 > LIM) ? LIM : m_cnt + 1) : 0;
         end else if (i_arvalid) begin
            m_owner = 1; m_ar = 1; m_id = 4'd0; m_cnt = 0;
            m_req   = '{i_araddr, i_arlen, 3'b010};
         end
      end else if (m_ar) begin
         if (arready) begin m_ar = 0; m_left = int'(m_req.len) + 1; m_beat = 0; end
      end else if (rvalid && exp_rr) begin
         if (rresp != 2'b00 && !m_err) begin m_err = 1; m_err_id = m_id; end
         m_beat++; m_left--;
         if (m_left == 0) m_owner = 0;
      end

      // bench-side bookkeeping of handshakes seen on the pins
      if (arvalid && arready) begin
         gnt_log.push_back(arid);
         s_busy = 1; s_left = int'(arlen) + 1; s_beat = 0; s_addr = araddr; s_id = arid;
         s_arcnt = 0; s_ardly = $urandom_range(3);
      end else if (arvalid) s_arcnt++;
      if (rvalid && rready && s_busy) begin
         s_beat++; s_left--;
         if (s_left == 0) s_busy = 0;
      end
      if (i_arready) i_arr_n++;
      if (i_rvalid && i_rready) i_rx_n++;
      if (d_rvalid && d_rready) d_rx.push_back(d_rdata);
      if (i_arvalid && i_arready && i_q.size() > 0) i_q.delete(0);
      if (d_arvalid && d_arready && d_q.size() > 0) d_q.delete(0);
   endtask

   task automatic cycle();
      sample();
      @(posedge aclk);
      #1;
      drive();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(m_owner == 0 && i_q.size() == 0 && d_q.size() == 0) && n < budget) begin
         cycle();
         n++;
      end
      chk("idle_timeout", n >= budget, 0);
      cycle();
   endtask

   task automatic do_reset();
      aresetn = 0;
      clr_bench();
      repeat (2) @(posedge aclk);
      #1 aresetn = 1;
   endtask

   task automatic chk_rst(input string tag);
      chk(tag, {arvalid, araddr, arlen, arid, arsize, rready, i_arready, d_arready, i_rvalid, d_rvalid},
          {1'b0, 32'h0, 8'h0, 4'h0, 3'b010, 5'b0});
   endtask

   initial begin
      int n;
      clr_bench();
      rvalid = 1; rlast = 1;
      repeat (2) @(posedge aclk);
      #1 chk_rst("rst_vals");
      rvalid = 0;

      // single i burst, arready two cycles late
      ardly_fix = 2;
      do_reset();
      i_q.push_back('{32'h1FC0_0000, 8'd7, 3'b010});
      i_arr_n = 0; i_rx_n = 0;
      drive();
      wait_idle(80);
      chk("t1_arready_pulses", i_arr_n, 1);
      chk("t1_beats", i_rx_n, 8);

      // simultaneous first requests: d first
      ardly_fix = 0;
      do_reset();
      gnt_log.delete();
      i_q.push_back('{32'h1FC0_0040, 8'd3, 3'b010});
      d_q.push_back('{32'h0000_0100, 8'd0, 3'b000});
      drive();
      wait_idle(80);
      chk("t2_order", log_word(2), 64'hFFFF_FFFF_FFFF_FF10);

      // d floods while i waits
      do_reset();
      gnt_log.delete();
      p_req = 100;
      drive();
      n = 0;
      while (gnt_log.size() < 10 && n < 400) begin cycle(); n++; end
      p_req = 0;
      wait_idle(200);
      chk("t3_order", log_word(10), 64'hFFFF_FF11_1101_1110);

      // d back-pressure mid-burst
      do_reset();
      use_tbl = 1; d_rx.delete(); bp_n = 0;
      d_q.push_back('{32'h0000_2000, 8'd3, 3'b010});
      drive();
      n = 0;
      while (d_rx.size() < 2 && n < 40) begin cycle(); n++; end
      d_rready = 0; d_hold = 2;
      wait_idle(60);
      use_tbl = 0;
      chk("t4_stall", bp_n, 3);
      chk("t4_n", d_rx.size(), 4);
      for (int k = 0; k < 4; k++) if (k < d_rx.size()) chk("t4_data", d_rx[k], tbl[k]);

      // reset during DATA
      do_reset();
      i_rx_n = 0;
      i_q.push_back('{32'h0000_3000, 8'd7, 3'b010});
      drive();
      n = 0;
      while (i_rx_n < 3 && n < 40) begin cycle(); n++; end
      #2 aresetn = 0;
      clr_bench();
      rvalid = 1; rlast = 1;
      #1 chk_rst("t5_async_rst");
      repeat (2) begin
         @(negedge aclk);
         chk("t5_stray", {rready, i_rvalid, d_rvalid, i_rlast && i_rvalid}, 4'b0);
      end
      @(posedge aclk);
      #1 aresetn = 1;
      i_rx_n = 0;
      i_q.push_back('{32'h0000_4000, 8'd3, 3'b010});
      drive();
      wait_idle(60);
      chk("t5_after", i_rx_n, 4);

`ifdef AXI_RD_ARB_RESP_ERR_EN
      // error on beat 2 of a d burst, then a clean i burst
      do_reset();
      err_beat = 1;
      d_q.push_back('{32'h0000_5000, 8'd3, 3'b010});
      drive();
      wait_idle(60);
      err_beat = -1;
      i_q.push_back('{32'h0000_6000, 8'd3, 3'b010});
      drive();
      wait_idle(60);
      chk("t6_err", {rd_err, rd_err_id}, {1'b1, 4'd1});
      p_err = 3;
`endif

      // random traffic
      ardly_fix = -1;
      do_reset();
      p_req = 30; p_rr = 70; p_rv = 70; p_stray = 20;
      drive();
      repeat (3000) cycle();
      p_req = 0;
      wait_idle(400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
